// File: rtl/adc_frame_buffer.sv
// Ping-pong frame buffer between the serial ADC reader and the FFT stage.
// Converts offset-binary samples to two's complement and hands full frames over by ownership.
module adc_frame_buffer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              frame_ready,
    output logic              rd_bank,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              frame_done,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int unsigned Depth = 2 ** (ADDR_W + 1);

    typedef enum logic {
        StIdle,
        StOwned
    } state_e;

    state_e            state_q, state_d;
    logic              wbank_q, wbank_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              rd_bank_q, rd_bank_d;
    logic              frame_ready_q, frame_ready_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [Depth];

    logic [DATA_W-1:0] sample_conv;
    logic              frame_last;
    logic              released;

    assign sample_conv = {~sample_data[DATA_W-1], sample_data[DATA_W-2:0]};
    assign frame_last  = sample_valid && (waddr_q == {ADDR_W{1'b1}});
    // A release in the same cycle as completion frees the bank before the swap decision.
    assign released    = (state_q == StIdle) || frame_done;

    always_comb begin
        state_d       = state_q;
        wbank_d       = wbank_q;
        waddr_d       = waddr_q;
        rd_bank_d     = rd_bank_q;
        frame_ready_d = 1'b0;
        overrun_d     = overrun_q;

        if (sample_valid) begin
            waddr_d = waddr_q + 1'b1;
        end

        if (state_q == StOwned && frame_done) begin
            state_d = StIdle;
        end

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (frame_last) begin
            if (released) begin
                rd_bank_d     = wbank_q;
                wbank_d       = ~wbank_q;
                frame_ready_d = 1'b1;
                state_d       = StOwned;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            wbank_q       <= 1'b0;
            waddr_q       <= '0;
            rd_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wbank_q       <= wbank_d;
            waddr_q       <= waddr_d;
            rd_bank_q     <= rd_bank_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
        end
    end

    // Storage is deliberately left unreset so it maps onto a plain RAM.
    always_ff @(posedge clk) begin
        if (sample_valid && !reset) begin
            mem[{wbank_q, waddr_q}] <= sample_conv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[{rd_bank_q, rd_addr}];
        end
    end

    assign frame_ready = frame_ready_q;
    assign rd_bank     = rd_bank_q;
    assign rd_data     = rd_data_q;
    assign busy        = (state_q == StOwned);
    assign overrun     = overrun_q;

endmodule
